// File: rtl/scratchpad_ctrl.sv
// Shares the scratchpad write/address port between single-element bus accesses
// and row-major serialisation of a latched result matrix, with alternating priority.
module scratchpad_ctrl #(
    parameter int BUS_WIDTH   = 32,
    parameter int MAX_DIM     = 4,
    parameter int ELEMENT_NUM = 4,
    parameter int ADDR_WIDTH  = 4,
    parameter int DIM_W       = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               bus_req_i,
    input  logic                               bus_we_i,
    input  logic [1:0]                         bus_sel_i,
    input  logic [ADDR_WIDTH-1:0]              bus_addr_i,
    input  logic [BUS_WIDTH-1:0]               bus_wdata_i,
    output logic                               bus_ack_o,
    output logic [BUS_WIDTH-1:0]               bus_rdata_o,
    input  logic                               res_valid_i,
    output logic                               res_ready_o,
    input  logic [1:0]                         res_sel_i,
    input  logic [DIM_W-1:0]                   res_rows_i,
    input  logic [DIM_W-1:0]                   res_cols_i,
    input  logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0] res_flat_i,
    output logic                               wb_busy_o,
    output logic                               wb_done_o,
    output logic [ADDR_WIDTH-1:0]              sp_addr_o,
    output logic [BUS_WIDTH-1:0]               sp_din_o,
    output logic                               sp_ien_o,
    output logic [1:0]                         sp_wsel_o,
    output logic [1:0]                         sp_rsel_o,
    input  logic [BUS_WIDTH-1:0]               sp_element_out_i,
    output logic [1:0]                         dbg_state_o,
    output logic                               dbg_slot_ok_o
);

    typedef enum logic [1:0] {IDLE, WB, DONE} state_t;

    state_t                 state_q;
    logic                   prio_q;
    logic [DIM_W-1:0]       r_q, c_q, rows_q, cols_q;
    logic [1:0]             slot_q;
    logic [BUS_WIDTH-1:0]   elem_q [MAX_DIM*MAX_DIM];

    logic bus_elig, wb_act, grant_bus, grant_wb;

    // Handshakes: the bus holds bus_req_i until bus_ack_o; a result moves on
    // the cycle res_valid_i && res_ready_o are both high at the rising edge.
    assign bus_elig  = bus_req_i && !bus_ack_o && !rst_i;
    assign wb_act    = (state_q == WB) && !rst_i;
    assign grant_bus = bus_elig && (!wb_act || !prio_q);
    assign grant_wb  = wb_act && (!bus_elig || prio_q);

    assign dbg_state_o   = state_q;
    assign dbg_slot_ok_o = 32'(slot_q) < ELEMENT_NUM;

    always_comb begin
        sp_ien_o  = 1'b0;
        sp_addr_o = '0;
        sp_din_o  = '0;
        sp_wsel_o = '0;
        sp_rsel_o = '0;
        if (grant_bus) begin
            sp_addr_o = bus_addr_i;
            if (bus_we_i) begin
                sp_ien_o  = 1'b1;
                sp_wsel_o = bus_sel_i;
                sp_din_o  = bus_wdata_i;
            end else begin
                sp_rsel_o = bus_sel_i;
            end
        end else if (grant_wb) begin
            sp_ien_o  = 1'b1;
            sp_wsel_o = slot_q;
            sp_addr_o = ADDR_WIDTH'({r_q, c_q});
            sp_din_o  = elem_q[{r_q, c_q}];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            r_q         <= '0;
            c_q         <= '0;
            rows_q      <= '0;
            cols_q      <= '0;
            slot_q      <= '0;
            bus_ack_o   <= 1'b0;
            bus_rdata_o <= '0;
            res_ready_o <= 1'b1;
            wb_busy_o   <= 1'b0;
            wb_done_o   <= 1'b0;
        end else begin
            bus_ack_o <= grant_bus;
            if (grant_bus && !bus_we_i)
                bus_rdata_o <= sp_element_out_i;
            // Only a genuine conflict flips priority.
            if (bus_elig && wb_act)
                prio_q <= !prio_q;
            wb_done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (res_valid_i && res_ready_o) begin
                        for (int j = 0; j < MAX_DIM*MAX_DIM; j++)
                            elem_q[j] <= res_flat_i[j*BUS_WIDTH +: BUS_WIDTH];
                        slot_q      <= res_sel_i;
                        rows_q      <= res_rows_i;
                        cols_q      <= res_cols_i;
                        r_q         <= '0;
                        c_q         <= '0;
                        state_q     <= WB;
                        res_ready_o <= 1'b0;
                        wb_busy_o   <= 1'b1;
                    end
                end
                WB: begin
                    if (grant_wb) begin
                        if (c_q == cols_q) begin
                            c_q <= '0;
                            if (r_q == rows_q) begin
                                state_q   <= DONE;
                                wb_done_o <= 1'b1;
                            end else begin
                                r_q <= r_q + 1'b1;
                            end
                        end else begin
                            c_q <= c_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    res_ready_o <= 1'b1;
                    wb_busy_o   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scratchpad_ctrl.sv
// Bench for scratchpad_ctrl: scratchpad memory model, element-level queue of
// expected scratchpad writes, reference memory contents and random traffic.
module tb_scratchpad_ctrl;
    localparam int BW  = 32;
    localparam int MD  = 4;
    localparam int AW  = 4;
    localparam int DW  = 2;
    localparam int NEL = MD*MD;
    localparam int W   = 2 + AW + BW;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              bus_req_i, bus_we_i;
    logic [1:0]        bus_sel_i;
    logic [AW-1:0]     bus_addr_i;
    logic [BW-1:0]     bus_wdata_i;
    logic              bus_ack_o;
    logic [BW-1:0]     bus_rdata_o;
    logic              res_valid_i, res_ready_o;
    logic [1:0]        res_sel_i;
    logic [DW-1:0]     res_rows_i, res_cols_i;
    logic [BW*NEL-1:0] res_flat_i;
    logic              wb_busy_o, wb_done_o;
    logic [AW-1:0]     sp_addr_o;
    logic [BW-1:0]     sp_din_o;
    logic              sp_ien_o;
    logic [1:0]        sp_wsel_o, sp_rsel_o;
    logic [BW-1:0]     sp_element_out_i;
    logic [1:0]        dbg_state_o;
    logic              dbg_slot_ok_o;

    logic [BW-1:0]     mem [4][NEL];
    logic [BW-1:0]     ref_mem [4][NEL];
    logic [W-1:0]      exp_q [$];
    logic [W-1:0]      mon_e;
    logic              mem_clr, arb_on, arb_exp_wb, arb_fin;
    int                n_checks, n_errors, cyc, wr_cnt, done_cnt, arb_n;

    scratchpad_ctrl dut (
        .clk_i(clk), .rst_i(rst_i),
        .bus_req_i(bus_req_i), .bus_we_i(bus_we_i), .bus_sel_i(bus_sel_i),
        .bus_addr_i(bus_addr_i), .bus_wdata_i(bus_wdata_i),
        .bus_ack_o(bus_ack_o), .bus_rdata_o(bus_rdata_o),
        .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_sel_i(res_sel_i),
        .res_rows_i(res_rows_i), .res_cols_i(res_cols_i), .res_flat_i(res_flat_i),
        .wb_busy_o(wb_busy_o), .wb_done_o(wb_done_o),
        .sp_addr_o(sp_addr_o), .sp_din_o(sp_din_o), .sp_ien_o(sp_ien_o),
        .sp_wsel_o(sp_wsel_o), .sp_rsel_o(sp_rsel_o),
        .sp_element_out_i(sp_element_out_i),
        .dbg_state_o(dbg_state_o), .dbg_slot_ok_o(dbg_slot_ok_o)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scratchpad model: combinational read, clocked write
    assign sp_element_out_i = mem[sp_rsel_o][sp_addr_o];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int s = 0; s < 4; s++)
                for (int a = 0; a < NEL; a++) mem[s][a] <= '0;
        end else if (sp_ien_o) begin
            mem[sp_wsel_o][sp_addr_o] <= sp_din_o;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every scratchpad write must be the next expected one
    always @(negedge clk) begin
        if (mem_clr) begin
            for (int s = 0; s < 4; s++)
                for (int a = 0; a < NEL; a++) ref_mem[s][a] = '0;
        end else begin
            if (wb_done_o) done_cnt++;
            if (sp_ien_o) begin
                if (rst_i || exp_q.size() == 0) begin
                    check("spurious_write", 64'(sp_ien_o), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sp_write", 64'({sp_wsel_o, sp_addr_o, sp_din_o}), 64'(mon_e));
                    ref_mem[mon_e[W-1 -: 2]][mon_e[BW+AW-1 -: AW]] = mon_e[BW-1:0];
                    wr_cnt++;
                end
            end
            if (arb_on && wb_busy_o && !wb_done_o && bus_req_i && !bus_ack_o) begin
                check("arb_order", 64'(sp_ien_o), 64'(arb_exp_wb));
                arb_exp_wb = !arb_exp_wb;
                arb_n++;
            end
        end
    end

    function automatic logic [BW*NEL-1:0] rand_flat();
        logic [BW*NEL-1:0] f;
        for (int j = 0; j < NEL; j++) f[j*BW +: BW] = $urandom();
        return f;
    endfunction

    task automatic push_expected(input logic [1:0] sel, input int rows, input int cols,
                                 input logic [BW*NEL-1:0] flat);
        for (int r = 0; r <= rows; r++)
            for (int c = 0; c <= cols; c++)
                exp_q.push_back({sel, AW'(r*MD + c), flat[(r*MD + c)*BW +: BW]});
    endtask

    // Drivers: all start and end at 1 time unit after a rising edge
    task automatic bus_access(input logic we, input logic [1:0] sel, input logic [AW-1:0] addr,
                              input logic [BW-1:0] wdata, output int lat, output logic [BW-1:0] rd);
        lat = 0;
        if (we) exp_q.push_back({sel, addr, wdata});
        bus_req_i = 1'b1; bus_we_i = we; bus_sel_i = sel; bus_addr_i = addr; bus_wdata_i = wdata;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus_ack_o && lat < 50);
        check("bus_ack", 64'(bus_ack_o), 64'd1);
        rd = bus_rdata_o;
        if (!we) check("bus_rdata", 64'(bus_rdata_o), 64'(ref_mem[sel][addr]));
        bus_req_i = 1'b0;
    endtask

    task automatic send_result(input logic [1:0] sel, input logic [DW-1:0] rows,
                               input logic [DW-1:0] cols, input logic [BW*NEL-1:0] flat,
                               output int acc);
        int   guard;
        logic rdy;
        push_expected(sel, int'(rows), int'(cols), flat);
        res_valid_i = 1'b1; res_sel_i = sel; res_rows_i = rows; res_cols_i = cols; res_flat_i = flat;
        guard = 0;
        do begin
            @(negedge clk); rdy = res_ready_o;
            @(posedge clk); guard++;
        end while (!rdy && guard < 100);
        check("res_accept", 64'(rdy), 64'd1);
        #1;
        res_valid_i = 1'b0;
        acc = cyc;
    endtask

    // delta = cycles from the accept edge to the done cycle (first write is 1)
    task automatic wait_done(input int acc, output int delta);
        int guard;
        guard = 0;
        delta = -1;
        while (guard < 200) begin
            @(negedge clk);
            guard++;
            if (wb_done_o) begin
                delta = cyc - acc + 1;
                break;
            end
        end
        check("done_seen", 64'(wb_done_o), 64'd1);
        check("done_no_pending", 64'(exp_q.size()), 64'd0);
        check("ready_in_done", 64'(res_ready_o), 64'd0);
        @(negedge clk);
        check("done_one_cycle", 64'(wb_done_o), 64'd0);
        check("ready_after_done", 64'(res_ready_o), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, acc, d, base, guard, dbase;
        logic [BW-1:0] rd;
        logic [BW*NEL-1:0] fa, fb;
        logic [DW-1:0] rr, cc;

        // Reset, with a bus write held to prove the port stays quiet
        rst_i = 1'b1; mem_clr = 1'b1; arb_on = 1'b0; arb_exp_wb = 1'b0; arb_fin = 1'b0;
        bus_req_i = 1'b1; bus_we_i = 1'b1; bus_sel_i = 2'd1; bus_addr_i = 4'd3; bus_wdata_i = 32'h1234;
        res_valid_i = 1'b0; res_sel_i = '0; res_rows_i = '0; res_cols_i = '0; res_flat_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sp_ien", 64'(sp_ien_o), 64'd0);
        @(posedge clk); #1;
        bus_req_i = 1'b0; rst_i = 1'b0; mem_clr = 1'b0;
        @(negedge clk);
        check("rst_ack", 64'(bus_ack_o), 64'd0);
        check("rst_rdata", 64'(bus_rdata_o), 64'd0);
        check("rst_busy", 64'(wb_busy_o), 64'd0);
        check("rst_done", 64'(wb_done_o), 64'd0);
        check("rst_ready", 64'(res_ready_o), 64'd1);
        @(posedge clk); #1;

        // Bus write then read of slot 2 address 5
        bus_access(1'b1, 2'd2, 4'd5, 32'hDEADBEEF, lat, rd);
        check("wr_lat", 64'(lat), 64'd1);
        @(posedge clk); #1;
        bus_access(1'b0, 2'd2, 4'd5, '0, lat, rd);
        check("rd_lat", 64'(lat), 64'd1);
        check("rd_deadbeef", 64'(rd), 64'hDEADBEEF);
        bus_access(1'b0, 2'd2, 4'd5, '0, lat, rd);
        check("b2b_lat", 64'(lat), 64'd2);

        // Full 4x4 result, element j = j+1
        for (int j = 0; j < NEL; j++) fa[j*BW +: BW] = BW'(j + 1);
        send_result(2'd1, 2'd3, 2'd3, fa, acc);
        wait_done(acc, d);
        check("done_4x4", 64'(d), 64'd17);

        // 2x3 result
        send_result(2'd0, 2'd1, 2'd2, rand_flat(), acc);
        wait_done(acc, d);
        check("done_2x3", 64'(d), 64'd7);

        // Contention: bus re-requests right after every ack
        arb_on = 1'b1; arb_exp_wb = 1'b0; arb_fin = 1'b0; arb_n = 0;
        fork
            begin
                send_result(2'd0, 2'd3, 2'd3, rand_flat(), acc);
                wait_done(acc, d);
                arb_fin = 1'b1;
            end
            begin
                while (!arb_fin)
                    bus_access(1'b0, 2'd3, AW'($urandom_range(0, NEL-1)), '0, lat, rd);
            end
        join
        arb_on = 1'b0;
        check("arb_within_32", 64'(d <= 33), 64'd1);
        check("arb_conflicts", 64'(arb_n >= 4), 64'd1);

        // Offer while busy: accepted only on the first IDLE cycle after DONE
        fa = rand_flat(); fb = rand_flat();
        send_result(2'd2, 2'd3, 2'd3, fa, acc);
        res_valid_i = 1'b1; res_sel_i = 2'd2; res_rows_i = 2'd1; res_cols_i = 2'd2; res_flat_i = fb;
        @(negedge clk);
        check("ready_low_in_wb", 64'(res_ready_o), 64'd0);
        @(posedge clk); #1;
        wait_done(acc, d);
        check("done_a", 64'(d), 64'd17);
        push_expected(2'd2, 1, 2, fb);
        acc = cyc;
        res_valid_i = 1'b0;
        check("b_accepted", 64'(wb_busy_o), 64'd1);
        wait_done(acc, d);
        check("done_b", 64'(d), 64'd7);

        // Reset after 5 of 16 writeback writes
        send_result(2'd1, 2'd3, 2'd3, rand_flat(), acc);
        base = wr_cnt; guard = 0;
        while (wr_cnt - base < 5 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("rst_after_5", 64'(wr_cnt - base), 64'd5);
        dbase = done_cnt;
        rst_i = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(wb_busy_o), 64'd0);
        check("midrst_ready", 64'(res_ready_o), 64'd1);
        check("midrst_ack", 64'(bus_ack_o), 64'd0);
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_done", 64'(done_cnt - dbase), 64'd0);
        for (int a = 0; a < 7; a++) bus_access(1'b0, 2'd1, AW'(a), '0, lat, rd);

        // Random mix of bus traffic and results
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: bus_access(1'b1, 2'($urandom_range(0, 3)), AW'($urandom_range(0, NEL-1)),
                              $urandom(), lat, rd);
                1, 2: bus_access(1'b0, 2'($urandom_range(0, 3)), AW'($urandom_range(0, NEL-1)),
                                 '0, lat, rd);
                default: begin
                    rr = DW'($urandom_range(0, MD-1));
                    cc = DW'($urandom_range(0, MD-1));
                    send_result(2'($urandom_range(0, 3)), rr, cc, rand_flat(), acc);
                    wait_done(acc, d);
                    check("done_rand", 64'(d), 64'((int'(rr) + 1) * (int'(cc) + 1) + 1));
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
